u_thermo_ramp_ctrl: RTL

Sequencer that moves a 6-bit level toward a requested target one code per programmable step interval and drives the matching 64-bit thermometer code from a register. It sits in front of the thermometer-coded actuator path, such as a current-steering DAC or bar-graph driver. It guarantees that only one output bit toggles per step and that no decode glitches reach the load. Targets arrive over a valid/ready handshake, and completion is reported with a one-cycle done pulse.

---
 rtl/u_thermo_ramp_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/u_thermo_ramp_ctrl.sv
// Thermometer-code ramp sequencer: walks a 6-bit level one code per STEP_DIV
// cycles toward an accepted target and drives the registered thermometer code.
module u_thermo_ramp_ctrl #(
    parameter int unsigned STEP_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_valid,
    input  logic [5:0]  i_target,
    output logic        o_ready,
    input  logic        i_hold,
    input  logic        i_abort,
    output logic [5:0]  o_level,
    output logic [63:0] o_therm,
    output logic        o_busy,
    output logic        o_done
);
    localparam logic [7:0] TIMER_LAST = 8'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP,
        ST_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [5:0]  target_q, target_d;
    logic [5:0]  level_q, level_d;
    logic [63:0] therm_q, therm_d;
    logic        done_q, done_d;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            target_q <= '0;
            level_q  <= '0;
            therm_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            target_q <= target_d;
            level_q  <= level_d;
            therm_q  <= therm_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        target_d = target_q;
        level_d  = level_q;
        therm_d  = '0;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    target_d = i_target;
                    timer_d  = '0;
                    state_d  = (i_target == level_q) ? ST_DONE : ST_RAMP;
                end
            end
            ST_RAMP: begin
                // Abort outranks both hold and a coincident step.
                if (i_abort) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (!i_hold) begin
                    if (timer_q == TIMER_LAST) begin
                        timer_d = '0;
                        level_d = (target_q > level_q) ? level_q + 6'd1 : level_q - 6'd1;
                        if (level_d == target_q) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Code derives from the next level so level and code change on the same edge.
        for (int unsigned i = 0; i < 64; i++) begin
            therm_d[i] = (i < {26'd0, level_d});
        end
        done_d = (state_d == ST_DONE);
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_busy  = (state_q == ST_RAMP);
    assign o_level = level_q;
    assign o_therm = therm_q;
    assign o_done  = done_q;

endmodule
